// File: rtl/clock_vip_ctrl.sv
// Clock VIP configuration sequencer: validates requests, then applies them to the generator via a
// stop -> quiesce -> load -> settle sequence. Optional watchdog: CLOCK_VIP_CTRL_WATCHDOG_EN.
module clock_vip_ctrl #(
  parameter int unsigned MIN_PERIOD_PS     = 1000,
  parameter int unsigned MAX_PERIOD_PS     = 100000000,
  parameter int unsigned DEFAULT_PERIOD_PS = 10000,
  parameter int unsigned QUIESCE_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES     = 8,
  parameter int unsigned WDOG_CYCLES       = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_enable_i,
  input  logic [31:0] req_period_ps_i,
  input  logic [7:0]  req_duty_i,
  input  logic [31:0] req_jitter_ps_i,
  input  logic        clock_in_i,
  output logic        enable_o,
  output logic [31:0] period_ps_o,
  output logic [7:0]  duty_cycle_o,
  output logic [31:0] jitter_ps_o,
  output logic        clock_active_o,
  output logic        config_error_o,
  output logic        busy_o,
  output logic        cfg_done_o,
  output logic        wdog_fault_o
);

  localparam int unsigned CntMax = (QUIESCE_CYCLES > SETTLE_CYCLES) ? QUIESCE_CYCLES
                                                                     : SETTLE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StCheck, StQuiesce, StSettle, StActive} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              hold_enable_q, hold_enable_d;
  logic [31:0]       hold_period_q, hold_period_d;
  logic [7:0]        hold_duty_q, hold_duty_d;
  logic [31:0]       hold_jitter_q, hold_jitter_d;
  logic              from_active_q, from_active_d;
  logic              enable_q, enable_d;
  logic [31:0]       period_q, period_d;
  logic [7:0]        duty_q, duty_d;
  logic [31:0]       jitter_q, jitter_d;
  logic              clock_active_q, clock_active_d;
  logic              config_error_q, config_error_d;
  logic              busy_q, busy_d;
  logic              cfg_done_q, cfg_done_d;
  logic              req_ready_q, req_ready_d;
  logic              accept, load_cfg, req_invalid, wdog_trip;
  logic              period_bad, duty_bad, jitter_bad;

  assign accept = req_valid_i & req_ready_q;

  assign period_bad  = (hold_period_q < MIN_PERIOD_PS) || (hold_period_q > MAX_PERIOD_PS);
  assign duty_bad    = (hold_duty_q == 8'd0) || (hold_duty_q >= 8'd100);
  // 2*jitter compared at 33 bits so a huge jitter cannot wrap into a legal value
  assign jitter_bad  = {hold_jitter_q, 1'b0} > {1'b0, hold_period_q};
  assign req_invalid = hold_enable_q & (period_bad | duty_bad | jitter_bad);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hold_enable_d  = hold_enable_q;
    hold_period_d  = hold_period_q;
    hold_duty_d    = hold_duty_q;
    hold_jitter_d  = hold_jitter_q;
    from_active_d  = from_active_q;
    enable_d       = enable_q;
    period_d       = period_q;
    duty_d         = duty_q;
    jitter_d       = jitter_q;
    clock_active_d = clock_active_q;
    config_error_d = config_error_q;
    cfg_done_d     = 1'b0;
    load_cfg       = 1'b0;

    unique case (state_q)
      StIdle, StActive: begin
        if (accept) begin
          hold_enable_d  = req_enable_i;
          hold_period_d  = req_period_ps_i;
          hold_duty_d    = req_duty_i;
          hold_jitter_d  = req_jitter_ps_i;
          from_active_d  = (state_q == StActive);
          config_error_d = 1'b0;
          state_d        = StCheck;
        end else if (wdog_trip) begin
          clock_active_d = 1'b0;
        end
      end
      StCheck: begin
        if (req_invalid) begin
          config_error_d = 1'b1;
          cfg_done_d     = 1'b1;
          state_d        = from_active_q ? StActive : StIdle;
        end else if (from_active_q) begin
          enable_d       = 1'b0;
          clock_active_d = 1'b0;
          cnt_d          = CntW'(QUIESCE_CYCLES - 1);
          state_d        = StQuiesce;
        end else if (hold_enable_q) begin
          load_cfg = 1'b1;
        end else begin
          cfg_done_d = 1'b1;
          state_d    = StIdle;
        end
      end
      StQuiesce: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (hold_enable_q) begin
          load_cfg = 1'b1;
        end else begin
          cfg_done_d = 1'b1;
          state_d    = StIdle;
        end
      end
      StSettle: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          clock_active_d = 1'b1;
          cfg_done_d     = 1'b1;
          state_d        = StActive;
        end
      end
      default: state_d = StIdle;
    endcase

    // Configuration only moves on the edge where enable rises
    if (load_cfg) begin
      period_d = hold_period_q;
      duty_d   = hold_duty_q;
      jitter_d = hold_jitter_q;
      enable_d = 1'b1;
      cnt_d    = CntW'(SETTLE_CYCLES - 1);
      state_d  = StSettle;
    end

    req_ready_d = (state_d == StIdle) || (state_d == StActive);
    busy_d      = (state_d == StCheck) || (state_d == StQuiesce) || (state_d == StSettle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      hold_enable_q  <= 1'b0;
      hold_period_q  <= '0;
      hold_duty_q    <= '0;
      hold_jitter_q  <= '0;
      from_active_q  <= 1'b0;
      enable_q       <= 1'b0;
      period_q       <= 32'(DEFAULT_PERIOD_PS);
      duty_q         <= 8'd50;
      jitter_q       <= '0;
      clock_active_q <= 1'b0;
      config_error_q <= 1'b0;
      busy_q         <= 1'b0;
      cfg_done_q     <= 1'b0;
      req_ready_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      hold_enable_q  <= hold_enable_d;
      hold_period_q  <= hold_period_d;
      hold_duty_q    <= hold_duty_d;
      hold_jitter_q  <= hold_jitter_d;
      from_active_q  <= from_active_d;
      enable_q       <= enable_d;
      period_q       <= period_d;
      duty_q         <= duty_d;
      jitter_q       <= jitter_d;
      clock_active_q <= clock_active_d;
      config_error_q <= config_error_d;
      busy_q         <= busy_d;
      cfg_done_q     <= cfg_done_d;
      req_ready_q    <= req_ready_d;
    end
  end

`ifdef CLOCK_VIP_CTRL_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(WDOG_CYCLES + 1);

  logic [2:0]     sync_q;
  logic [WdW-1:0] wdog_cnt_q;
  logic           wdog_fault_q;
  logic           fb_edge;

  // sync_q[1:0] is the synchronizer, sync_q[2] the previous value for edge detection
  assign fb_edge   = sync_q[2] ^ sync_q[1];
  assign wdog_trip = (state_q == StActive) && !fb_edge &&
                     (wdog_cnt_q == WdW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q       <= '0;
      wdog_cnt_q   <= '0;
      wdog_fault_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], clock_in_i};
      if ((state_q != StActive) || fb_edge) begin
        wdog_cnt_q <= '0;
      end else if (wdog_cnt_q != WdW'(WDOG_CYCLES)) begin
        wdog_cnt_q <= wdog_cnt_q + WdW'(1);
      end
      if (accept) begin
        wdog_fault_q <= 1'b0;
      end else if (wdog_trip) begin
        wdog_fault_q <= 1'b1;
      end
    end
  end

  assign wdog_fault_o = wdog_fault_q;
`else
  logic unused_clock_in;
  assign unused_clock_in = clock_in_i | (WDOG_CYCLES == 0);
  assign wdog_trip       = 1'b0;
  assign wdog_fault_o    = 1'b0;
`endif

  assign req_ready_o    = req_ready_q;
  assign enable_o       = enable_q;
  assign period_ps_o    = period_q;
  assign duty_cycle_o   = duty_q;
  assign jitter_ps_o    = jitter_q;
  assign clock_active_o = clock_active_q;
  assign config_error_o = config_error_q;
  assign busy_o         = busy_q;
  assign cfg_done_o     = cfg_done_q;

endmodule

// File: doc/clock_vip_ctrl.md
Name: clock_vip_ctrl

Overview:
- Configuration sequencer placed between the test/sequence layer and the clock VIP generator.
- Accepts clock configuration requests over a valid/ready handshake and validates each one.
- Applies an accepted request to the generator control signals (enable, period_ps, duty_cycle, jitter_ps) using a glitch-safe stop → quiesce → load → settle sequence.
- Reports clock_active, config_error and completion.

Parameters:
- MIN_PERIOD_PS, 1000, smallest legal period_ps.
- MAX_PERIOD_PS, 100000000, largest legal period_ps.
- DEFAULT_PERIOD_PS, 10000, period_ps value after reset.
- QUIESCE_CYCLES, 4, clk cycles enable is held low before a new configuration is loaded (≥1).
- SETTLE_CYCLES, 8, clk cycles after enable rises before clock_active is asserted (≥1).
- WDOG_CYCLES, 256, watchdog timeout in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  control clock; the single clock of the block
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  configuration request valid
- req_ready  output  1  request can be accepted
- req_enable  input  1  1 = run the clock with this configuration, 0 = stop the clock
- req_period_ps  input  32  requested period
- req_duty  input  8  requested duty cycle, percent
- req_jitter_ps  input  32  requested peak-to-peak jitter
- clock_in  input  1  generated clock fed back (used by the watchdog only)
- enable  output  1  generator enable
- period_ps  output  32  applied period
- duty_cycle  output  8  applied duty cycle
- jitter_ps  output  32  applied jitter
- clock_active  output  1  clock running and settled
- config_error  output  1  last request was rejected (sticky)
- busy  output  1  a sequence is in progress
- cfg_done  output  1  one-cycle pulse when a request completes or is rejected
- wdog_fault  output  1  feedback clock stalled (sticky)

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: enable=0, period_ps=DEFAULT_PERIOD_PS, duty_cycle=50, jitter_ps=0, clock_active=0, config_error=0, busy=0, cfg_done=0, wdog_fault=0, req_ready=0.
- Reset mid-sequence aborts the sequence. All outputs take their reset values on the next edge.
- States: IDLE, CHECK, QUIESCE, SETTLE, ACTIVE.
- req_ready=1 only in IDLE or ACTIVE. busy=1 in CHECK, QUIESCE and SETTLE.
- Accept edge E: req_valid & req_ready. The request is captured into holding registers, state becomes CHECK, and config_error is cleared.
- Validation in CHECK. A request is invalid when any of these holds:
  - req_enable=1 and period < MIN_PERIOD_PS or period > MAX_PERIOD_PS;
  - duty == 0 or duty ≥ 100;
  - 2×jitter > period, computed at 33 bits with no overflow.
- A disable request (req_enable=0) is never invalid.
- Invalid request, at edge E+1: config_error=1, cfg_done pulses, state returns to its pre-accept state (IDLE or ACTIVE). Generator outputs are untouched.
- Valid enable request from IDLE, at edge E+1: period_ps, duty_cycle and jitter_ps are loaded, enable=1, state becomes SETTLE.
- Valid request from ACTIVE, at edge E+1: enable=0, clock_active=0, state becomes QUIESCE.
- After QUIESCE_CYCLES cycles in QUIESCE (edge E+1+QUIESCE_CYCLES):
  - enable request: load the configuration, enable=1, go to SETTLE;
  - disable request: cfg_done pulses, go to IDLE.
- Valid disable request from IDLE, at edge E+1: cfg_done pulses, state returns to IDLE. No output changes.
- SETTLE exit: SETTLE_CYCLES edges after enable rises, clock_active=1, cfg_done pulses, state becomes ACTIVE.
- period_ps, duty_cycle and jitter_ps change only while enable=0 or on the same edge enable rises. They never change while enable=1.
- Counters reload on every state entry. There is no wrap-around; a counter stops at 0.
- req_valid while req_ready=0 is held by the requester and is not lost.

Optional Feature:
- Macro: CLOCK_VIP_CTRL_WATCHDOG_EN.
- With the macro defined:
  - clock_in passes through a 2-flop synchronizer; edge detection runs on the synchronized value.
  - In ACTIVE, a counter resets on each detected clock_in edge.
  - When the counter reaches WDOG_CYCLES: wdog_fault=1 (sticky until rst or the next accepted request), clock_active=0. State remains ACTIVE and enable remains 1.
- Without the macro: wdog_fault is tied to 0 and clock_in is ignored.

Test Plan:
- Reset, then request {en=1, period=10000, duty=50, jitter=0} accepted at edge E → enable=1 and period_ps=10000 at E+1; clock_active=1 and a cfg_done pulse at E+9; busy=1 from E through E+8.
- From ACTIVE, request period=20000 → enable falls at E+1; outputs still 10000 through E+4; enable=1 with period_ps=20000 at E+5; clock_active=1 at E+13.
- Request duty=0, then period=500, then jitter=6000 with period=10000 → each gives config_error=1 and a cfg_done pulse at E+1; enable, period_ps and clock_active unchanged; the next valid request clears config_error.
- From ACTIVE, request en=0 → enable=0 and clock_active=0 at E+1; cfg_done at E+5; state IDLE with req_ready=1.
- Assert rst during QUIESCE → all outputs at reset values the following cycle; period_ps=10000, duty_cycle=50.
- With CLOCK_VIP_CTRL_WATCHDOG_EN, ACTIVE with clock_in held at 0 → wdog_fault=1 and clock_active=0 after 256 cycles; a toggling clock_in keeps wdog_fault=0.
